coord_gen: RTL and testbench

//  - Maps VGA raster counters (640x480@60, 800x525 total) to text-cell coordinates.
//  - Outputs the character column x, character row y and the pixel offset inside the cell.
//  - Outputs an active-area flag.
//  - Sits between the sync/counter generator and the char_gen font/RAM lookup.
//  - All outputs are registered.

---
 rtl/coord_gen_pkg.sv | 45 ++++
 rtl/coord_axis.sv | 26 ++
 rtl/coord_gen.sv | 89 ++++++++
 tb/tb_coord_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/coord_gen_pkg.sv
// Shared timing constants, widths and types for the VGA raster-to-text-cell mapper.
// Consumed by coord_axis and coord_gen (optional macro COORD_GEN_BLANK_EN lives in coord_gen).
package coord_gen_pkg;

   localparam int H_TOTAL      = 800;
   localparam int V_TOTAL      = 525;
   localparam int H_ACTIVE     = 640;
   localparam int V_ACTIVE     = 480;

   localparam int CHAR_W       = 8;
   localparam int CHAR_H       = 16;
   localparam int CHAR_W_SHIFT = $clog2(CHAR_W);
   localparam int CHAR_H_SHIFT = $clog2(CHAR_H);

   localparam int COLS         = 80;
   localparam int ROWS         = 30;

   localparam int CNT_W        = 10;
   localparam int COORD_W      = 7;

   typedef logic [CNT_W-1:0]   cnt_t;
   typedef logic [COORD_W-1:0] coord_t;

   localparam coord_t COORD_MAX = 7'h7F;

   typedef struct packed {
      coord_t                  x;
      coord_t                  y;
      logic [CHAR_W_SHIFT-1:0] col_off;
      logic [CHAR_H_SHIFT-1:0] row_off;
      logic                    active;
   } coord_out_t;

   // Clamp a shifted counter to the largest representable cell index.
   function automatic coord_t sat_coord(input cnt_t idx);
      coord_t res;
      if (idx > cnt_t'(COORD_MAX)) begin
         res = COORD_MAX;
      end else begin
         res = idx[COORD_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/coord_axis.sv
// One raster axis: cell index (saturated shift), offset inside the cell and
// in-active-range flag, all combinational.
module coord_axis
   import coord_gen_pkg::*;
#(
   parameter int ACTIVE = H_ACTIVE,
   parameter int CELL   = CHAR_W,
   parameter int OFF_W  = $clog2(CELL)
) (
   input  logic [CNT_W-1:0]   cnt_i,
   output logic [COORD_W-1:0] idx_o,
   output logic [OFF_W-1:0]   off_o,
   output logic               in_range_o
);

   logic [CNT_W-1:0] shifted_s;

   // CELL is a power of two, so the cell index is a plain right shift.
   always_comb begin
      shifted_s  = cnt_i >> OFF_W;
      idx_o      = sat_coord(shifted_s);
      off_o      = cnt_i[OFF_W-1:0];
      in_range_o = (cnt_i < CNT_W'(ACTIVE));
   end

endmodule

// File: rtl/coord_gen.sv
// Registers text-cell coordinates derived from the VGA H/V counters (1-cycle latency).
// Define COORD_GEN_BLANK_EN to force x=y=7'h7F and zero offsets outside the active area.
module coord_gen
   import coord_gen_pkg::*;
(
   input  logic               clock25,
   input  logic               reset_n,
   input  logic [CNT_W-1:0]   HorizontalCounter,
   input  logic [CNT_W-1:0]   VerticalCounter,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [2:0]         col_off,
   output logic [3:0]         row_off,
   output logic               active
);

   logic [COORD_W-1:0]      h_idx_s;
   logic [COORD_W-1:0]      v_idx_s;
   logic [CHAR_W_SHIFT-1:0] h_off_s;
   logic [CHAR_H_SHIFT-1:0] v_off_s;
   logic                    h_in_s;
   logic                    v_in_s;
   logic                    act_s;
   coord_out_t              out_d;
   coord_out_t              out_q;

   coord_axis #(
      .ACTIVE (H_ACTIVE),
      .CELL   (CHAR_W)
   ) u_h_axis (
      .cnt_i      (HorizontalCounter),
      .idx_o      (h_idx_s),
      .off_o      (h_off_s),
      .in_range_o (h_in_s)
   );

   coord_axis #(
      .ACTIVE (V_ACTIVE),
      .CELL   (CHAR_H)
   ) u_v_axis (
      .cnt_i      (VerticalCounter),
      .idx_o      (v_idx_s),
      .off_o      (v_off_s),
      .in_range_o (v_in_s)
   );

   // Next-state output bundle, optionally masked during blanking.
   always_comb begin
      out_d = '0;
      act_s = h_in_s & v_in_s;
`ifdef COORD_GEN_BLANK_EN
      if (act_s) begin
         out_d.x       = h_idx_s;
         out_d.y       = v_idx_s;
         out_d.col_off = h_off_s;
         out_d.row_off = v_off_s;
         out_d.active  = 1'b1;
      end else begin
         out_d.x       = COORD_MAX;
         out_d.y       = COORD_MAX;
         out_d.col_off = '0;
         out_d.row_off = '0;
         out_d.active  = 1'b0;
      end
`else
      out_d.x       = h_idx_s;
      out_d.y       = v_idx_s;
      out_d.col_off = h_off_s;
      out_d.row_off = v_off_s;
      out_d.active  = act_s;
`endif
   end

   // Output register; reset clears everything in both builds.
   always_ff @(posedge clock25 or negedge reset_n) begin
      if (!reset_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign x       = out_q.x;
   assign y       = out_q.y;
   assign col_off = out_q.col_off;
   assign row_off = out_q.row_off;
   assign active  = out_q.active;

endmodule

// File: tb/tb_coord_gen.sv
// Directed self-checking bench for coord_gen: reset, latency, cell edges,
// blanking, out-of-range inputs, mid-frame reset and a continuous raster sweep.
module tb_coord_gen;

   logic       clock25 = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] hc = 10'd0;
   logic [9:0] vc = 10'd0;
   logic [6:0] x;
   logic [6:0] y;
   logic [2:0] col_off;
   logic [3:0] row_off;
   logic       active;

   int n_checks = 0;
   int n_fail   = 0;

   wire [21:0] obs = {x, y, col_off, row_off, active};

   coord_gen dut (
      .clock25           (clock25),
      .reset_n           (reset_n),
      .HorizontalCounter (hc),
      .VerticalCounter   (vc),
      .x                 (x),
      .y                 (y),
      .col_off           (col_off),
      .row_off           (row_off),
      .active            (active)
   );

   always #20 clock25 = ~clock25;

   // Reference: division/modulo formulation, independent of the shift datapath.
   function automatic logic [21:0] exp_vec(input int h, input int v);
      logic act;
      int   xi;
      int   yi;
      act = (h < 640) && (v < 480);
      xi  = h / 8;
      yi  = v / 16;
      if (xi > 127) xi = 127;
      if (yi > 127) yi = 127;
`ifdef COORD_GEN_BLANK_EN
      if (!act) return {7'h7F, 7'h7F, 3'd0, 4'd0, 1'b0};
`endif
      return {xi[6:0], yi[6:0], 3'(h % 8), 4'(v % 16), act};
   endfunction

   // Drive one input pair after an edge, let it be sampled, observe at the next negedge.
   task automatic apply(input int h, input int v);
      @(posedge clock25); #1;
      hc = 10'(h);
      vc = 10'(v);
      @(posedge clock25);
      @(negedge clock25);
   endtask

   task automatic test_reset();
      logic [21:0] e;
      reset_n = 1'b0; hc = 10'd100; vc = 10'd100;
      repeat (3) @(posedge clock25);
      @(negedge clock25);
      n_checks++; if (obs !== 22'd0) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, 22'd0); end
      reset_n = 1'b1;
      #1;
      n_checks++; if (obs !== 22'd0) begin n_fail++; $display("FAIL reset_release_no_edge: got %h expected %h", obs, 22'd0); end
      @(posedge clock25); @(negedge clock25);
      e = {7'd12, 7'd6, 3'd4, 4'd4, 1'b1};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL reset_first_edge: got %h expected %h", obs, e); end
   endtask

   task automatic test_origin();
      logic [21:0] e_old;
      logic [21:0] e;
      e_old = {7'd12, 7'd6, 3'd4, 4'd4, 1'b1};
      e     = {7'd0, 7'd0, 3'd0, 4'd0, 1'b1};
      @(posedge clock25); #1;
      hc = 10'd0; vc = 10'd0;
      @(negedge clock25);
      n_checks++; if (obs !== e_old) begin n_fail++; $display("FAIL latency_hold: got %h expected %h", obs, e_old); end
      @(posedge clock25); @(negedge clock25);
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL origin: got %h expected %h", obs, e); end
   endtask

   task automatic test_cell_edges();
      logic [21:0] e;
      apply(7, 15);
      e = {7'd0, 7'd0, 3'd7, 4'd15, 1'b1};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL edge_7_15: got %h expected %h", obs, e); end
      apply(8, 16);
      e = {7'd1, 7'd1, 3'd0, 4'd0, 1'b1};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL edge_8_16: got %h expected %h", obs, e); end
      apply(639, 479);
      e = {7'd79, 7'd29, 3'd7, 4'd15, 1'b1};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL last_visible: got %h expected %h", obs, e); end
   endtask

   task automatic test_blanking();
      logic [21:0] e;
      apply(640, 0);
`ifdef COORD_GEN_BLANK_EN
      e = {7'h7F, 7'h7F, 3'd0, 4'd0, 1'b0};
`else
      e = {7'd80, 7'd0, 3'd0, 4'd0, 1'b0};
`endif
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL blank_h640: got %h expected %h", obs, e); end
      apply(0, 480);
`ifdef COORD_GEN_BLANK_EN
      e = {7'h7F, 7'h7F, 3'd0, 4'd0, 1'b0};
`else
      e = {7'd0, 7'd30, 3'd0, 4'd0, 1'b0};
`endif
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL blank_v480: got %h expected %h", obs, e); end
      apply(799, 524);
`ifdef COORD_GEN_BLANK_EN
      e = {7'h7F, 7'h7F, 3'd0, 4'd0, 1'b0};
`else
      e = {7'd99, 7'd32, 3'd7, 4'd12, 1'b0};
`endif
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL blank_corner: got %h expected %h", obs, e); end
      apply(1023, 1023);
`ifdef COORD_GEN_BLANK_EN
      e = {7'h7F, 7'h7F, 3'd0, 4'd0, 1'b0};
`else
      e = {7'd127, 7'd63, 3'd7, 4'd15, 1'b0};
`endif
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL out_of_range: got %h expected %h", obs, e); end
   endtask

   task automatic test_reset_mid();
      logic [21:0] e;
      apply(320, 240);
      e = {7'd40, 7'd15, 3'd0, 4'd0, 1'b1};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL mid_before_reset: got %h expected %h", obs, e); end
      #5 reset_n = 1'b0;
      #1;
      n_checks++; if (obs !== 22'd0) begin n_fail++; $display("FAIL mid_reset_clear: got %h expected %h", obs, 22'd0); end
      @(posedge clock25); @(negedge clock25);
      reset_n = 1'b1;
      #1;
      n_checks++; if (obs !== 22'd0) begin n_fail++; $display("FAIL mid_release_no_edge: got %h expected %h", obs, 22'd0); end
      @(posedge clock25); @(negedge clock25);
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL mid_resume: got %h expected %h", obs, e); end
   endtask

   task automatic test_back_to_back();
      int lines [17] = '{0, 1, 15, 16, 17, 31, 32, 239, 240, 478, 479, 480, 481, 511, 512, 523, 524};
      int hpts [6]   = '{0, 7, 8, 639, 640, 799};
      int ph = 0;
      int pv = 0;
      bit have_prev = 1'b0;
      logic [21:0] e;
      for (int f = 0; f < 2; f++) begin
         for (int li = 0; li < 17; li++) begin
            for (int h = 0; h < 800; h++) begin
               @(posedge clock25); #1;
               hc = 10'(h); vc = 10'(lines[li]);
               @(negedge clock25);
               if (have_prev) begin
                  e = exp_vec(ph, pv);
                  n_checks++; if (obs !== e) begin n_fail++; $display("FAIL sweep h=%0d v=%0d: got %h expected %h", ph, pv, obs, e); end
`ifndef COORD_GEN_BLANK_EN
                  n_checks++; if (x > 7'd99 || y > 7'd32) begin n_fail++; $display("FAIL sweep_range h=%0d v=%0d: got x=%0d y=%0d expected x<=99 y<=32", ph, pv, x, y); end
`endif
               end
               ph = h; pv = lines[li]; have_prev = 1'b1;
            end
         end
      end
      for (int v = 0; v < 525; v++) begin
         for (int k = 0; k < 6; k++) begin
            @(posedge clock25); #1;
            hc = 10'(hpts[k]); vc = 10'(v);
            @(negedge clock25);
            e = exp_vec(ph, pv);
            n_checks++; if (obs !== e) begin n_fail++; $display("FAIL vsweep h=%0d v=%0d: got %h expected %h", ph, pv, obs, e); end
            ph = hpts[k]; pv = v;
         end
      end
   endtask

   initial begin
      test_reset();
      test_origin();
      test_cell_edges();
      test_blanking();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
